// File: rtl/sub_unit_scheduler.sv
// Round-robin scheduler sharing one 64-bit subtract unit.
// Optional overflow counter: define SUB_SCHED_OVF_CNT_EN.
module sub_unit_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SUB_SCHED_OVF_CNT_EN
  input  logic                  ovf_clr,
  output logic [15:0]           ovf_count,
`endif
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*64-1:0] req_a,
  input  logic [NUM_REQ*64-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [63:0]           resp_result,
  output logic                  resp_overflow
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] gnt_q, gnt_d;
  logic [63:0]      a_q, a_d;
  logic [63:0]      b_q, b_d;
  logic [63:0]      res_q, res_d;
  logic             ovf_q, ovf_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [PTR_W-1:0]   scan_gnt;
  logic               scan_hit;
  logic [PTR_W:0]     scan_sum;
  logic [NUM_REQ-1:0] grant_oh;
  logic [63:0]        a_sel;
  logic [63:0]        b_sel;
  logic [63:0]        diff;
  logic [PTR_W-1:0]   ptr_nxt;
  logic               req_hs;
  logic               resp_hs;

  // Find the first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    scan_hit = 1'b0;
    scan_gnt = '0;
    scan_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      end
      if (!scan_hit && req_valid[scan_sum[PTR_W-1:0]]) begin
        scan_hit = 1'b1;
        scan_gnt = scan_sum[PTR_W-1:0];
      end
    end
  end

  assign grant_oh = NUM_REQ'(1) << scan_gnt;

  // Accept only in IDLE and never while reset is asserted.
  assign req_hs = (state_q == ST_IDLE) && !rst && scan_hit;
  assign req_ready = req_hs ? grant_oh : '0;

  // Operand mux for the granted requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_oh[k]) begin
        a_sel = req_a[k*64 +: 64];
        b_sel = req_b[k*64 +: 64];
      end
    end
  end

  assign diff = a_q + ~b_q + 64'd1;

  assign ptr_nxt = (gnt_q == PTR_W'(NUM_REQ-1))
                 ? '0 : gnt_q + 1'b1;

  assign resp_hs = (state_q == ST_RESP) && resp_ready;

  // Next-state logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    id_d     = id_q;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          a_d     = a_sel;
          b_d     = b_sel;
          gnt_d   = scan_gnt;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = diff;
        // Sign rule on the operands, safe for B = most-negative.
        ovf_d   = (a_q[63] != b_q[63]) && (diff[63] != a_q[63]);
        id_d    = ID_W'(gnt_q);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d  = ST_IDLE;
          rr_ptr_d = ptr_nxt;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      id_q     <= id_d;
    end
  end

  assign resp_valid    = (state_q == ST_RESP);
  assign resp_id       = id_q;
  assign resp_result   = res_q;
  assign resp_overflow = ovf_q;

`ifdef SUB_SCHED_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of overflowing responses; clear wins.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = '0;
    end else if (resp_hs && ovf_q && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_sub_unit_scheduler.sv
// Bench for sub_unit_scheduler: vector table, scoreboard,
// and hand sequences for fairness, backpressure and reset.
module tb_sub_unit_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*64-1:0] req_a;
  logic [N*64-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [63:0]    resp_result;
  logic           resp_overflow;
`ifdef SUB_SCHED_OVF_CNT_EN
  logic           ovf_clr;
  logic [15:0]    ovf_count;
`endif

  always #5 clk = ~clk;

  sub_unit_scheduler #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SUB_SCHED_OVF_CNT_EN
    .ovf_clr(ovf_clr),
    .ovf_count(ovf_count),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id(resp_id),
    .resp_result(resp_result),
    .resp_overflow(resp_overflow)
  );

  typedef struct {
    logic [1:0]  id;
    logic [63:0] r;
    logic        o;
  } exp_t;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        o;
  } vec_t;

  exp_t sb[$];
  vec_t vt[8];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_resp = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic mdl_ovf(input logic [63:0] a,
                                   input logic [63:0] b);
    logic [64:0] d;
    d = {a[63], a} - {b[63], b};
    return d[64] ^ d[63];
  endfunction

  // Response monitor: handshake happens on the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && resp_valid && resp_ready) begin
        n_resp++;
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_resp: got id %0d want none",
                   resp_id);
        end else begin
          e = sb.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_result", resp_result, e.r);
          chk("resp_overflow", 64'(resp_overflow), 64'(e.o));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic do_op(input int id,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] r, input logic o,
                       input bit push);
    bit   got;
    exp_t e;
    @(negedge clk);
    req_a[id*64 +: 64] = a;
    req_b[id*64 +: 64] = b;
    req_valid = N'(1) << id;
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (|req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      chk("grant_timeout", 64'd0, 64'd1);
    end else begin
      chk("req_ready", 64'(req_ready), 64'(N'(1) << id));
      if (push) begin
        e.id = 2'(id);
        e.r  = r;
        e.o  = o;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rr_seq(input logic [N-1:0] mask,
                        input int exp_ids[8], input int cnt);
    bit   got;
    int   last;
    exp_t e;
    last = 0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      req_a[k*64 +: 64] = 64'(100 + k);
      req_b[k*64 +: 64] = 64'(k);
    end
    req_valid = mask;
    for (int j = 0; j < cnt; j++) begin
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        #1;
        if (|req_ready) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!got) begin
        chk("rr_timeout", 64'd0, 64'd1);
        break;
      end
      chk("rr_grant", 64'(req_ready), 64'(N'(1) << exp_ids[j]));
      if (j > 0) chk("rr_gap", 64'(cyc - last), 64'd3);
      last = cyc;
      e.id = 2'(exp_ids[j]);
      e.r  = 64'd100;
      e.o  = 1'b0;
      sb.push_back(e);
      @(negedge clk);
    end
  endtask

  initial begin
    int s1[8];
    int s2[8];
    logic [63:0] ra, rb;
    int rid;
    exp_t e;

    s1 = '{0, 1, 2, 3, 0, 1, 2, 3};
    s2 = '{0, 1, 3, 0, 1, 3, 0, 0};
    vt[0] = '{0, 64'd10, 64'd3, 64'd7, 1'b0};
    vt[1] = '{1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1'b1};
    vt[2] = '{2, 64'd0, 64'h8000_0000_0000_0000,
              64'h8000_0000_0000_0000, 1'b1};
    vt[3] = '{3, 64'd5, 64'd5, 64'd0, 1'b0};
    vt[4] = '{0, 64'h8000_0000_0000_0000, 64'd1,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    vt[5] = '{1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'd0, 1'b0};
    vt[6] = '{2, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[7] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1'b0};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b1;
`ifdef SUB_SCHED_OVF_CNT_EN
    ovf_clr = 1'b0;
`endif

    // Reset state, including no accept while rst is high.
    @(negedge clk);
    @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_result", resp_result, 64'd0);
    chk("rst_resp_ovf", 64'(resp_overflow), 64'd0);
`ifdef SUB_SCHED_OVF_CNT_EN
    chk("rst_ovf_count", 64'(ovf_count), 64'd0);
`endif
    req_valid = '0;
    rst = 1'b0;

    // Single request with latency and one-cycle ready.
    @(negedge clk);
    req_a[63:0] = 64'd10;
    req_b[63:0] = 64'd3;
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 64'(req_ready), 64'b0001);
    e.id = 2'd0;
    e.r  = 64'd7;
    e.o  = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    #1;
    chk("exec_ready", 64'(req_ready), 64'd0);
    chk("exec_valid", 64'(resp_valid), 64'd0);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("resp_latency", 64'(resp_valid), 64'd1);
    @(negedge clk);
    #1;
    chk("resp_drop", 64'(resp_valid), 64'd0);
    wait_idle();

    // Arithmetic vector table.
    for (int i = 0; i < 8; i++) begin
      do_op(vt[i].id, vt[i].a, vt[i].b, vt[i].r, vt[i].o, 1'b1);
      wait_idle();
    end

    // Random operands checked against the 65-bit model.
    for (int i = 0; i < 6; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rid = $urandom_range(0, N-1);
      do_op(rid, ra, rb, ra - rb, mdl_ovf(ra, rb), 1'b1);
      wait_idle();
    end

    // Round-robin with all valid, then with requester 2 dropped.
    do_reset();
    rr_seq(4'b1111, s1, 8);
    rr_seq(4'b1011, s2, 6);
    @(negedge clk);
    req_valid = '0;
    wait_idle();

    // Backpressure: held outputs, no new accept, one response.
    resp_ready = 1'b0;
    do_op(1, 64'd20, 64'd5, 64'd15, 1'b0, 1'b1);
    req_valid = '1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_id", 64'(resp_id), 64'd1);
      chk("bp_result", resp_result, 64'd15);
      chk("bp_ovf", 64'(resp_overflow), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rid = n_resp;
    @(negedge clk);
    req_valid = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    #3;
    chk("bp_one_resp", 64'(n_resp - rid), 64'd1);
    chk("bp_valid_drop", 64'(resp_valid), 64'd0);
    wait_idle();

    // Reset during EXEC: no response, pointer back to 0.
    do_op(1, 64'd9, 64'd4, 64'd5, 1'b0, 1'b1);
    wait_idle();
    do_op(2, 64'd50, 64'd1, 64'd49, 1'b0, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      req_a[k*64 +: 64] = 64'(30 + k);
      req_b[k*64 +: 64] = 64'd1;
    end
    req_valid = '1;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(resp_valid), 64'd0);
    chk("midrst_grant0", 64'(req_ready), 64'b0001);
    e.id = 2'd0;
    e.r  = 64'd29;
    e.o  = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    req_valid = '0;
    wait_idle();

`ifdef SUB_SCHED_OVF_CNT_EN
    // Overflow counter and clear priority.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 1'b1, 1'b1);
      wait_idle();
    end
    chk("ovf_count3", 64'(ovf_count), 64'd3);
    do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1'b1, 1'b1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #1;
    chk("ovf_clr_prio", 64'(ovf_count), 64'd0);
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sub_unit_scheduler.md
Name: sub_unit_scheduler

Overview:
- Shares one 64-bit two's-complement subtract unit among NUM_REQ requesters.
- Grants requesters in round-robin order and captures operands with a valid/ready handshake.
- Computes A − B with signed-overflow detection and returns a tagged response over a valid/ready response channel.
- Sits between client engines and the integer datapath; the datapath sees one operation in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, 2, response ID width; must be ≥ clog2(NUM_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*64  minuend, packed; requester i occupies [64i+63:64i].
- req_b  input  NUM_REQ*64  subtrahend, packed in the same layout.
- resp_valid  output  1  response valid.
- resp_ready  input  1  consumer accepts response.
- resp_id  output  ID_W  index of the requester that owns the response.
- resp_result  output  64  A − B mod 2^64.
- resp_overflow  output  1  signed overflow of A − B.

Behaviour:
- Clock and reset
  - Single clock domain, clk.
  - rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values
  - State = IDLE, rr_ptr = 0.
  - req_ready = 0, resp_valid = 0, resp_id = 0, resp_result = 0, resp_overflow = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - grant = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready = one-hot(grant), driven combinationally. It is 0 when no request is valid.
  - On an edge with a handshake: latch A, B and grant, then go to EXEC.
- EXEC: one cycle.
  - Register result = A + ~B + 1, truncated to 64 bits.
  - Register overflow = (A[63] != B[63]) && (result[63] != A[63]).
    - This is correct for B = 0x8000_0000_0000_0000.
    - It must NOT be derived from the sign of the negated B.
  - resp_id = latched grant.
  - Go to RESP.
- RESP
  - resp_valid = 1. resp_id, resp_result and resp_overflow are held stable until the handshake.
  - On resp_valid & resp_ready:
    - go to IDLE;
    - rr_ptr = (grant + 1) mod NUM_REQ;
    - resp_valid deasserts on the following cycle.
- Handshake rules
  - req_ready is 0 in EXEC and RESP, so at most one operation is in flight.
  - A requester may drop req_valid before it is granted; it is not latched.
- Latency and throughput
  - Request handshake at edge T → resp_valid high from the cycle after edge T+1, i.e. 2 cycles after acceptance.
  - Maximum throughput is one operation per 3 cycles when resp_ready is held at 1.
- Fairness
  - With all requesters continuously valid, grants cycle 0,1,…,NUM_REQ−1,0…
  - No requester waits more than NUM_REQ operations.
- Wrap-around: rr_ptr wraps from NUM_REQ−1 to 0.
- Arithmetic is modulo 2^64; there is no saturation.
- Reset mid-operation: an in-flight operation is discarded and no response is emitted. All state returns to reset values on that edge.
- req_ready is never asserted in the same cycle rst is high.

Optional Feature:
- Macro: SUB_SCHED_OVF_CNT_EN.
- Defined
  - Adds output ovf_count (16 bits).
  - It increments on each response handshake with resp_overflow=1 and saturates at 0xFFFF.
  - It resets to 0 on rst.
  - It is additionally cleared when input ovf_clr (1 bit) is high; ovf_clr has priority over the increment in the same cycle.
- Not defined: the ovf_count and ovf_clr ports do not exist, and the other behaviour is identical.

Test Plan:
- Single request: req_valid=0001, A=10, B=3, resp_ready=1 → req_ready=0001 for one cycle; resp_valid 2 cycles later; resp_id=0, resp_result=7, resp_overflow=0.
- Overflow cases:
  - A=0x7FFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFF → result 0x8000_0000_0000_0000, overflow=1.
  - A=0, B=0x8000_0000_0000_0000 → result 0x8000_0000_0000_0000, overflow=1.
  - A=5, B=5 → result 0, overflow=0.
- Round-robin: all 4 requesters held valid for 8 operations → resp_id sequence 0,1,2,3,0,1,2,3. Dropping requester 2 → sequence skips 2 without a stall.
- Backpressure: resp_ready=0 for 5 cycles in RESP → outputs stable; req_ready stays 0000; exactly one response after resp_ready=1.
- Reset mid-op: rst=1 during EXEC → no resp_valid; next grant goes to requester 0 (rr_ptr=0).
- With SUB_SCHED_OVF_CNT_EN defined: 3 overflowing ops → ovf_count=3. ovf_clr pulsed in the same cycle as a 4th overflowing handshake → ovf_count=0.
